// File: rtl/alu_exec_unit.sv
// RV32I execute stage: Opcode/FuncCode decode into a 7-bit control word, 32-bit ALU and branch compare.
// Define ALU_COMB_OUT_EN to bypass the output register (ALUOut/Branch_Enable become combinational).
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  Opcode,
    input  logic [3:0]  FuncCode,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [6:0]  ALUCtl,
    output logic [31:0] ALUOut,
    output logic        Branch_Enable
);

    localparam logic [3:0] OP_AND  = 4'h0, OP_OR   = 4'h1, OP_ADD  = 4'h2, OP_SUB  = 4'h3,
                           OP_SLT  = 4'h4, OP_SLTU = 4'h5, OP_SRL  = 4'h6, OP_SRA  = 4'h7,
                           OP_SLL  = 4'h8, OP_XOR  = 4'h9, OP_PASS = 4'hA, OP_NOP  = 4'hF;

    localparam logic [2:0] BR_NONE = 3'd0, BR_EQ  = 3'd1, BR_NE  = 3'd2, BR_LT = 3'd3,
                           BR_GE   = 3'd4, BR_LTU = 3'd5, BR_GEU = 3'd6;

    logic [3:0]  op;
    logic [2:0]  cond;
    logic [2:0]  f3;
    logic        f30;
    logic [4:0]  shamt;
    logic [31:0] alu_out_d;
    logic        branch_en_d;

    assign f3    = FuncCode[2:0];
    assign f30   = FuncCode[3];
    assign shamt = B[4:0];

    always_comb begin
        op   = OP_NOP;
        cond = BR_NONE;
        case (Opcode)
            7'b0110011, 7'b0010011: begin
                case (f3)
                    3'b000:  op = (f30 && Opcode == 7'b0110011) ? OP_SUB : OP_ADD;
                    3'b001:  op = OP_SLL;
                    3'b010:  op = OP_SLT;
                    3'b011:  op = OP_SLTU;
                    3'b100:  op = OP_XOR;
                    3'b101:  op = f30 ? OP_SRA : OP_SRL;
                    3'b110:  op = OP_OR;
                    default: op = OP_AND;
                endcase
            end
            7'b0000011, 7'b0100011, 7'b1100111, 7'b1101111, 7'b0010111: op = OP_ADD;
            7'b0110111: op = OP_PASS;
            7'b1100011: begin
                case (f3)
                    3'b000:  cond = BR_EQ;
                    3'b001:  cond = BR_NE;
                    3'b100:  cond = BR_LT;
                    3'b101:  cond = BR_GE;
                    3'b110:  cond = BR_LTU;
                    3'b111:  cond = BR_GEU;
                    default: cond = BR_NONE;
                endcase
            end
            default: ;
        endcase
    end

    assign ALUCtl = {cond, op};

    always_comb begin
        alu_out_d = 32'd0;
        case (op)
            OP_AND:  alu_out_d = A & B;
            OP_OR:   alu_out_d = A | B;
            OP_ADD:  alu_out_d = A + B;
            OP_SUB:  alu_out_d = A - B;
            OP_SLT:  alu_out_d = {31'd0, $signed(A) < $signed(B)};
            OP_SLTU: alu_out_d = {31'd0, A < B};
            OP_SRL:  alu_out_d = A >> shamt;
            OP_SRA:  alu_out_d = $unsigned($signed(A) >>> shamt);
            OP_SLL:  alu_out_d = A << shamt;
            OP_XOR:  alu_out_d = A ^ B;
            OP_PASS: alu_out_d = B;
            default: alu_out_d = 32'd0;
        endcase
    end

    always_comb begin
        branch_en_d = 1'b0;
        case (cond)
            BR_EQ:   branch_en_d = (A == B);
            BR_NE:   branch_en_d = (A != B);
            BR_LT:   branch_en_d = ($signed(A) <  $signed(B));
            BR_GE:   branch_en_d = ($signed(A) >= $signed(B));
            BR_LTU:  branch_en_d = (A <  B);
            BR_GEU:  branch_en_d = (A >= B);
            default: branch_en_d = 1'b0;
        endcase
    end

`ifdef ALU_COMB_OUT_EN
    assign ALUOut        = alu_out_d;
    assign Branch_Enable = branch_en_d;
`else
    logic [31:0] alu_out_q;
    logic        branch_en_q;

    // Reset wins over the incoming operation, dropping any in-flight result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out_q   <= 32'd0;
            branch_en_q <= 1'b0;
        end else begin
            alu_out_q   <= alu_out_d;
            branch_en_q <= branch_en_d;
        end
    end

    assign ALUOut        = alu_out_q;
    assign Branch_Enable = branch_en_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit (registered build): expectations queued at drive, compared one cycle later.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic [6:0]  Opcode;
    logic [3:0]  FuncCode;
    logic [31:0] A;
    logic [31:0] B;
    logic [6:0]  ALUCtl;
    logic [31:0] ALUOut;
    logic        Branch_Enable;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] eo;
        logic        eb;
        string       nm;
    } exp_t;

    typedef struct {
        logic [6:0]  op;
        logic [3:0]  fc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eo;
        logic        eb;
    } vec_t;

    exp_t sb[$];

    localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_BR = 7'b1100011,
                           OPC_LUI = 7'b0110111;

    alu_exec_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Opcode        (Opcode),
        .FuncCode      (FuncCode),
        .A             (A),
        .B             (B),
        .ALUCtl        (ALUCtl),
        .ALUOut        (ALUOut),
        .Branch_Enable (Branch_Enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [6:0] op, input logic [3:0] fc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eo, input logic eb,
                         input string nm);
        @(negedge clk);
        Opcode   = op;
        FuncCode = fc;
        A        = a;
        B        = b;
        sb.push_back('{eo, eb, nm});
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n    = 1'b0;
        Opcode   = OPC_R;
        FuncCode = 4'b0000;
        A        = 32'hFFFF_FFFF;
        B        = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        sb.push_back('{32'd0, 1'b0, "reset"});
        #1;
        e = sb.pop_front();
        n_vec++;
        if (ALUOut !== e.eo || Branch_Enable !== e.eb) begin
            n_err++;
            $display("FAIL %s: got ALUOut=%h BE=%b, expected ALUOut=%h BE=%b",
                     e.nm, ALUOut, Branch_Enable, e.eo, e.eb);
        end
        n_vec++;
        if (ALUCtl !== 7'h02) begin
            n_err++;
            $display("FAIL reset_aluctl: got %h, expected %h", ALUCtl, 7'h02);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_table(input string nm, input vec_t v[$]);
        exp_t e;
        foreach (v[i]) begin
            drive(v[i].op, v[i].fc, v[i].a, v[i].b, v[i].eo, v[i].eb, $sformatf("%s[%0d]", nm, i));
            @(posedge clk);
            #1;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL %s: scoreboard empty, expected an entry", nm);
            end else begin
                e = sb.pop_front();
                if (ALUOut !== e.eo || Branch_Enable !== e.eb) begin
                    n_err++;
                    $display("FAIL %s: got ALUOut=%h BE=%b, expected ALUOut=%h BE=%b",
                             e.nm, ALUOut, Branch_Enable, e.eo, e.eb);
                end
            end
        end
    endtask

    task automatic test_logic_arith();
        vec_t v[$];
        v.push_back('{OPC_R, 4'b0111, 32'h0F, 32'h55, 32'h05, 1'b0});
        v.push_back('{OPC_R, 4'b0110, 32'h0F, 32'h55, 32'h5F, 1'b0});
        v.push_back('{OPC_R, 4'b0100, 32'h55, 32'hFF, 32'hAA, 1'b0});
        v.push_back('{OPC_R, 4'b0000, 32'd10000, 32'd111, 32'd10111, 1'b0});
        v.push_back('{OPC_R, 4'b1000, 32'd10000, 32'd111, 32'd9889, 1'b0});
        v.push_back('{OPC_R, 4'b1000, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0});
        v.push_back('{OPC_I, 4'b1000, 32'd3, 32'd4, 32'd7, 1'b0});
        v.push_back('{OPC_LUI, 4'b0000, 32'd1, 32'h1234_5000, 32'h1234_5000, 1'b0});
        v.push_back('{7'b0000000, 4'b0000, 32'd7, 32'd9, 32'd0, 1'b0});
        test_table("logic_arith", v);
    endtask

    task automatic test_compare_shift();
        vec_t v[$];
        v.push_back('{OPC_R, 4'b0010, 32'd0, 32'd2, 32'd1, 1'b0});
        v.push_back('{OPC_R, 4'b0010, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0});
        v.push_back('{OPC_R, 4'b0011, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0});
        v.push_back('{OPC_R, 4'b0101, 32'h10, 32'd2, 32'd4, 1'b0});
        v.push_back('{OPC_R, 4'b1101, 32'd8, 32'd1, 32'd4, 1'b0});
        v.push_back('{OPC_R, 4'b1101, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b0});
        v.push_back('{OPC_R, 4'b0001, 32'd2, 32'd2, 32'd8, 1'b0});
        v.push_back('{OPC_I, 4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0});
        v.push_back('{OPC_I, 4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0});
        test_table("compare_shift", v);
    endtask

    task automatic test_branch();
        vec_t v[$];
        v.push_back('{OPC_BR, 4'b0000, 32'd5, 32'd5, 32'd0, 1'b1});
        v.push_back('{OPC_BR, 4'b0001, 32'd5, 32'd5, 32'd0, 1'b0});
        v.push_back('{OPC_BR, 4'b0110, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1});
        v.push_back('{OPC_BR, 4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1});
        v.push_back('{OPC_BR, 4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0});
        v.push_back('{OPC_BR, 4'b0111, 32'd1, 32'd1, 32'd0, 1'b1});
        v.push_back('{OPC_BR, 4'b0010, 32'd1, 32'd2, 32'd0, 1'b0});
        v.push_back('{OPC_BR, 4'b0011, 32'd1, 32'd1, 32'd0, 1'b0});
        test_table("branch", v);
    endtask

    task automatic test_aluctl();
        logic [6:0] opc [7];
        logic [3:0] fc  [7];
        logic [6:0] ex  [7];
        opc = '{OPC_R, OPC_I, OPC_I, OPC_BR, OPC_BR, OPC_LUI, 7'b1111111};
        fc  = '{4'b1000, 4'b1000, 4'b1101, 4'b0111, 4'b0010, 4'b0000, 4'b0000};
        ex  = '{7'h03, 7'h02, 7'h07, 7'h6F, 7'h0F, 7'h0A, 7'h0F};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            Opcode   = opc[i];
            FuncCode = fc[i];
            #1;
            n_vec++;
            if (ALUCtl !== ex[i]) begin
                n_err++;
                $display("FAIL aluctl[%0d]: got %h, expected %h", i, ALUCtl, ex[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] a, b, eo;
        logic [3:0]  fc;
        logic [6:0]  opc;
        logic        eb;
        for (int i = 0; i < 24; i++) begin
            a   = $urandom;
            b   = $urandom;
            opc = OPC_R;
            eb  = 1'b0;
            case (i % 5)
                0: begin fc = 4'b0000; eo = a + b; end
                1: begin fc = 4'b1000; eo = a - b; end
                2: begin fc = 4'b0100; eo = a ^ b; end
                3: begin fc = 4'b0111; eo = a & b; end
                default: begin opc = OPC_BR; fc = 4'b0110; eo = 32'd0; eb = (a < b); end
            endcase
            drive(opc, fc, a, b, eo, eb, $sformatf("b2b[%0d]", i));
            @(posedge clk);
            #1;
            n_vec++;
            e = sb.pop_front();
            if (ALUOut !== e.eo || Branch_Enable !== e.eb) begin
                n_err++;
                $display("FAIL %s: got ALUOut=%h BE=%b, expected ALUOut=%h BE=%b",
                         e.nm, ALUOut, Branch_Enable, e.eo, e.eb);
            end
        end
    endtask

    task automatic test_reset_midstream();
        vec_t v[$];
        exp_t e;
        v.push_back('{OPC_R, 4'b0000, 32'd1, 32'd2, 32'd3, 1'b0});
        test_table("pre_reset", v);
        drive(OPC_BR, 4'b0000, 32'd9, 32'd9, 32'd0, 1'b0, "reset_priority");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        e = sb.pop_front();
        if (ALUOut !== e.eo || Branch_Enable !== e.eb) begin
            n_err++;
            $display("FAIL %s: got ALUOut=%h BE=%b, expected ALUOut=%h BE=%b",
                     e.nm, ALUOut, Branch_Enable, e.eo, e.eb);
        end
        drive(OPC_R, 4'b0110, 32'hF0, 32'h0F, 32'hFF, 1'b0, "post_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        e = sb.pop_front();
        if (ALUOut !== e.eo || Branch_Enable !== e.eb) begin
            n_err++;
            $display("FAIL %s: got ALUOut=%h BE=%b, expected ALUOut=%h BE=%b",
                     e.nm, ALUOut, Branch_Enable, e.eo, e.eb);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        Opcode   = OPC_R;
        FuncCode = 4'b0000;
        A        = 32'hFFFF_FFFF;
        B        = 32'hFFFF_FFFF;
        test_reset();
        test_logic_arith();
        test_compare_shift();
        test_branch();
        test_aluctl();
        test_back_to_back();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
